// File: rtl/pwm_capture_macro_if.sv
// Wishbone classic bus bundle for the PWM capture block.
// The slave modport is what the capture block sees; the master modport is what a bus master drives.
interface pwm_capture_macro_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_ack_o;
    logic        wb_err_o;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/pwm_capture_macro.sv
// Multi-channel PWM input capture: measures period and high time of each input in clk cycles
// and exposes results, valid and timeout flags through a Wishbone register bank.
module pwm_capture_macro #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    pwm_capture_macro_if.slave  wb,
    input  logic [NUM_CH-1:0]   pwm_in,
    output logic                irq
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    logic              en_q;
    logic [NUM_CH-1:0] valid_q, valid_d;
    logic [NUM_CH-1:0] tout_q, tout_d;
    logic [NUM_CH-1:0] ien_valid_q;
    logic [NUM_CH-1:0] ien_tout_q;
    logic              ack_q;
    logic [31:0]       dat_q;

    logic [NUM_CH-1:0] cap_set;
    logic [NUM_CH-1:0] tout_set;
    logic [CNT_W-1:0]  period_w [NUM_CH];
    logic [CNT_W-1:0]  high_w   [NUM_CH];

    logic        access;
    logic        wr_en;
    logic        rd_en;
    logic [5:0]  reg_idx;
    logic        wr_ctrl, wr_status, wr_ien;
    logic [31:0] rd_data;
    logic [31:0] status_word;
    logic [31:0] ien_word;
    logic [NUM_CH-1:0] clr_valid, clr_tout;
    logic        unused_bus;

    // A strobe is accepted only while ack is low, so held strobes are acked every other cycle.
    assign access    = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
    assign wr_en     = access & wb.wb_we_i;
    assign rd_en     = access & ~wb.wb_we_i;
    assign reg_idx   = wb.wb_adr_i[7:2];
    assign wr_ctrl   = wr_en && (reg_idx == 6'd0);
    assign wr_status = wr_en && (reg_idx == 6'd1);
    assign wr_ien    = wr_en && (reg_idx == 6'd2);

    assign unused_bus = ^{wb.wb_sel_i, wb.wb_adr_i[31:8], wb.wb_adr_i[1:0], wb.wb_dat_i};

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_dat_o = dat_q;
    assign wb.wb_err_o = 1'b0;

    always_comb begin
        status_word                 = '0;
        status_word[NUM_CH-1:0]     = valid_q;
        status_word[16 +: NUM_CH]   = tout_q;
        ien_word                    = '0;
        ien_word[NUM_CH-1:0]        = ien_valid_q;
        ien_word[16 +: NUM_CH]      = ien_tout_q;
    end

    always_comb begin
        rd_data = '0;
        case (reg_idx)
            6'd0:    rd_data = {31'd0, en_q};
            6'd1:    rd_data = status_word;
            6'd2:    rd_data = ien_word;
            default: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (reg_idx == 6'(4 + 2 * i)) rd_data = 32'(period_w[i]);
                    if (reg_idx == 6'(5 + 2 * i)) rd_data = 32'(high_w[i]);
                end
            end
        endcase
    end

    // Hardware set is OR'ed in after the W1C mask so a same-cycle capture survives the clear.
    always_comb begin
        clr_valid = '0;
        clr_tout  = '0;
        if (wr_status) begin
            clr_valid = wb.wb_dat_i[NUM_CH-1:0];
            clr_tout  = wb.wb_dat_i[16 +: NUM_CH];
        end
        valid_d = (valid_q & ~clr_valid) | cap_set;
        tout_d  = (tout_q & ~clr_tout) | tout_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q       <= 1'b0;
            dat_q       <= '0;
            en_q        <= 1'b0;
            ien_valid_q <= '0;
            ien_tout_q  <= '0;
            valid_q     <= '0;
            tout_q      <= '0;
        end else begin
            ack_q   <= access;
            valid_q <= valid_d;
            tout_q  <= tout_d;
            if (rd_en) begin
                dat_q <= rd_data;
            end
            if (wr_ctrl) begin
                en_q <= wb.wb_dat_i[0];
            end
            if (wr_ien) begin
                ien_valid_q <= wb.wb_dat_i[NUM_CH-1:0];
                ien_tout_q  <= wb.wb_dat_i[16 +: NUM_CH];
            end
        end
    end

    assign irq = |((valid_q & ien_valid_q) | (tout_q & ien_tout_q));

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   prev_q;
        logic                   rise;
        logic                   fall;
        state_t                 state_q, state_d;
        logic [CNT_W-1:0]       cnt_q, cnt_d;
        logic [CNT_W-1:0]       hcnt_q, hcnt_d;
        logic [CNT_W-1:0]       period_q, period_d;
        logic [CNT_W-1:0]       high_q, high_d;
        logic [CNT_W:0]         sum;
        logic                   cap_evt;
        logic                   tout_evt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= '0;
                prev_q <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in[gi]};
                prev_q <= sync_q[SYNC_STAGES-1];
            end
        end

        assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
        assign fall = ~sync_q[SYNC_STAGES-1] & prev_q;
        assign sum  = {1'b0, hcnt_q} + {1'b0, cnt_q};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q  <= ST_IDLE;
                cnt_q    <= '0;
                hcnt_q   <= '0;
                period_q <= '0;
                high_q   <= '0;
            end else begin
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                hcnt_q   <= hcnt_d;
                period_q <= period_d;
                high_q   <= high_d;
            end
        end

        always_comb begin
            state_d  = state_q;
            cnt_d    = cnt_q;
            hcnt_d   = hcnt_q;
            period_d = period_q;
            high_d   = high_q;
            cap_evt  = 1'b0;
            tout_evt = 1'b0;
            if (!en_q) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                hcnt_d  = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (rise) begin
                            cnt_d   = CNT_ONE;
                            state_d = ST_HIGH;
                        end
                    end
                    ST_HIGH: begin
                        if (fall) begin
                            hcnt_d  = cnt_q;
                            cnt_d   = CNT_ONE;
                            state_d = ST_LOW;
                        end else if (cnt_q == CNT_MAX) begin
                            tout_evt = 1'b1;
                            cnt_d    = '0;
                            state_d  = ST_IDLE;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                    ST_LOW: begin
                        if (rise) begin
                            // Period saturates rather than wrapping when high+low overflows.
                            period_d = sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
                            high_d   = hcnt_q;
                            cap_evt  = 1'b1;
                            cnt_d    = CNT_ONE;
                            state_d  = ST_HIGH;
                        end else if (cnt_q == CNT_MAX) begin
                            tout_evt = 1'b1;
                            cnt_d    = '0;
                            state_d  = ST_IDLE;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end
        end

        assign cap_set[gi]  = cap_evt;
        assign tout_set[gi] = tout_evt;
        assign period_w[gi] = period_q;
        assign high_w[gi]   = high_q;
    end

endmodule
